// File: rtl/divsqrt_prenorm.sv
// divsqrt_prenorm
//   Operand pre-normalization and result-exponent unit for the divide/sqrt
//   datapath. Captures raw mantissas and biased exponents and left-normalizes
//   subnormal mantissas with an iterative shifter (8 or 1 bit per cycle). It
//   then computes the result exponent DivUe and the sqrt odd-exponent flag.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   Flush                synchronous abort back to IDLE (beats Start)
//   Start / Ready        request handshake; Ready is high only in IDLE
//   SqrtE                1 = sqrt(X), 0 = X/Y; sampled at accept
//   Xe, Ye               biased exponents
//   XSubnorm, YSubnorm   operand is subnormal (effective exponent 1)
//   XMant, YMant         mantissas incl. integer bit (MSB)
//   XNorm, YNorm         normalized mantissas
//   DivUe                two's-complement biased result exponent (NE+2 bits)
//   SqrtOdd              unbiased sqrt exponent was odd
//   Valid / OutReady     result handshake; results held until OutReady

module divsqrt_prenorm #(
  parameter int NE = 11,
  parameter int NF = 52
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          Flush,
  input  logic          Start,
  output logic          Ready,
  input  logic          SqrtE,
  input  logic [NE-1:0] Xe,
  input  logic [NE-1:0] Ye,
  input  logic          XSubnorm,
  input  logic          YSubnorm,
  input  logic [NF:0]   XMant,
  input  logic [NF:0]   YMant,
  output logic [NF:0]   XNorm,
  output logic [NF:0]   YNorm,
  output logic [NE+1:0] DivUe,
  output logic          SqrtOdd,
  output logic          Valid,
  input  logic          OutReady
);

  localparam int LZW = $clog2(NF + 2);
  localparam int EW  = NE + 2;
  localparam logic [EW-1:0] BIAS = EW'((1 << (NE - 1)) - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORMX = 3'd1,
    NORMY = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Captured operands
  logic          sqrt_reg;
  logic [NE-1:0] xe_reg, ye_reg;
  logic          xsub_reg, ysub_reg;

  // Mantissa shift registers double as the XNorm/YNorm outputs
  logic [NF:0]    xnorm_reg, ynorm_reg;
  logic [LZW-1:0] xlz_reg, ylz_reg;
  logic [EW-1:0]  divue_reg;
  logic           sqrtodd_reg;

  // One normalization step per operand
  logic           x_done, y_done;
  logic [NF:0]    xnorm_next, ynorm_next;
  logic [LZW-1:0] xlz_next, ylz_next;

  always_comb begin
    x_done = (xnorm_reg == '0) || xnorm_reg[NF];
    if (xnorm_reg[NF -: 8] == 8'd0) begin
      xnorm_next = xnorm_reg << 8;
      xlz_next   = xlz_reg + LZW'(8);
    end else begin
      xnorm_next = xnorm_reg << 1;
      xlz_next   = xlz_reg + LZW'(1);
    end
  end

  always_comb begin
    y_done = (ynorm_reg == '0) || ynorm_reg[NF];
    if (ynorm_reg[NF -: 8] == 8'd0) begin
      ynorm_next = ynorm_reg << 8;
      ylz_next   = ylz_reg + LZW'(8);
    end else begin
      ynorm_next = ynorm_reg << 1;
      ylz_next   = ylz_reg + LZW'(1);
    end
  end

  // Exponent arithmetic, all in NE+2 bit two's complement
  logic [EW-1:0]        xee, yee, x_exp, y_exp, div_exp, sqrt_e, sqrt_exp;
  logic signed [EW-1:0] sqrt_half;
  logic                 sqrt_odd;

  always_comb begin
    xee      = xsub_reg ? EW'(1) : EW'(xe_reg);
    yee      = ysub_reg ? EW'(1) : EW'(ye_reg);
    x_exp    = xee - EW'(xlz_reg);
    y_exp    = yee - EW'(ylz_reg);
    div_exp  = x_exp - y_exp + BIAS;
    sqrt_e   = x_exp - BIAS;
    sqrt_odd = sqrt_e[0];
    // E - odd is even, so the arithmetic shift halves it exactly (incl. negatives)
    sqrt_half = $signed(sqrt_e - EW'(sqrt_odd)) >>> 1;
    sqrt_exp  = $unsigned(sqrt_half) + BIAS;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (Flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (Start)    state_next = NORMX;
        NORMX:   if (x_done)   state_next = sqrt_reg ? CALC : NORMY;
        NORMY:   if (y_done)   state_next = CALC;
        CALC:                  state_next = DONE;
        DONE:    if (OutReady) state_next = IDLE;
        default:               state_next = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    Ready = (state_reg == IDLE);
    Valid = (state_reg == DONE);
  end

  // Datapath registers; a flush freezes them rather than clearing them
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sqrt_reg    <= 1'b0;
      xe_reg      <= '0;
      ye_reg      <= '0;
      xsub_reg    <= 1'b0;
      ysub_reg    <= 1'b0;
      xnorm_reg   <= '0;
      ynorm_reg   <= '0;
      xlz_reg     <= '0;
      ylz_reg     <= '0;
      divue_reg   <= '0;
      sqrtodd_reg <= 1'b0;
    end else if (!Flush) begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            sqrt_reg  <= SqrtE;
            xe_reg    <= Xe;
            ye_reg    <= Ye;
            xsub_reg  <= XSubnorm;
            ysub_reg  <= YSubnorm;
            xnorm_reg <= XMant;
            ynorm_reg <= YMant;
            xlz_reg   <= '0;
            ylz_reg   <= '0;
          end
        end
        NORMX: begin
          if (!x_done) begin
            xnorm_reg <= xnorm_next;
            xlz_reg   <= xlz_next;
          end
        end
        NORMY: begin
          if (!y_done) begin
            ynorm_reg <= ynorm_next;
            ylz_reg   <= ylz_next;
          end
        end
        CALC: begin
          divue_reg   <= sqrt_reg ? sqrt_exp : div_exp;
          sqrtodd_reg <= sqrt_reg & sqrt_odd;
        end
        default: ;
      endcase
    end
  end

  assign XNorm   = xnorm_reg;
  assign YNorm   = ynorm_reg;
  assign DivUe   = divue_reg;
  assign SqrtOdd = sqrtodd_reg;

endmodule

// File: tb/tb_divsqrt_prenorm.sv
// Self-checking bench for divsqrt_prenorm: a table of hand-computed vectors,
// hand-written flush / reset / backpressure sequences, and randomized
// operations checked against an arithmetic reference model.

module tb_divsqrt_prenorm;

  logic        clk = 1'b0;
  logic        resetn;
  logic        Flush, Start, Ready, SqrtE;
  logic [10:0] Xe, Ye;
  logic        XSubnorm, YSubnorm;
  logic [52:0] XMant, YMant, XNorm, YNorm;
  logic [12:0] DivUe;
  logic        SqrtOdd, Valid, OutReady;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  divsqrt_prenorm dut (
    .clk(clk), .resetn(resetn), .Flush(Flush), .Start(Start), .Ready(Ready),
    .SqrtE(SqrtE), .Xe(Xe), .Ye(Ye), .XSubnorm(XSubnorm), .YSubnorm(YSubnorm),
    .XMant(XMant), .YMant(YMant), .XNorm(XNorm), .YNorm(YNorm),
    .DivUe(DivUe), .SqrtOdd(SqrtOdd), .Valid(Valid), .OutReady(OutReady)
  );

  typedef struct {
    logic        is_sqrt;
    logic [10:0] xe, ye;
    logic        xs, ys;
    logic [52:0] xm, ym;
    logic [52:0] exp_xn, exp_yn;
    logic [12:0] exp_ue;
    logic        exp_odd;
    int          exp_lat;
  } vec_t;

  localparam logic [52:0] ONE = 53'h10000000000000;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic sq, input logic [10:0] xe, input logic xs,
                              input logic [52:0] xm, input logic [10:0] ye, input logic ys,
                              input logic [52:0] ym, input logic [52:0] exn,
                              input logic [52:0] eyn, input logic [12:0] eue,
                              input logic eodd, input int lat);
    vec_t v;
    v.is_sqrt = sq; v.xe = xe; v.xs = xs; v.xm = xm; v.ye = ye; v.ys = ys; v.ym = ym;
    v.exp_xn = exn; v.exp_yn = eyn; v.exp_ue = eue; v.exp_odd = eodd; v.exp_lat = lat;
    return v;
  endfunction

  // Reference model: leading-zero count by scanning bits, exponents by integer math
  function automatic int lzc(input logic [52:0] m);
    int n = 0;
    if (m == 0) return 0;
    while (m[52-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int xlz, ylz, xee, yee, e, odd, xk, yk, ue;
    xlz = lzc(v.xm);
    ylz = lzc(v.ym);
    xk  = xlz / 8 + xlz % 8;   // shift-by-8 steps then shift-by-1 steps
    yk  = ylz / 8 + ylz % 8;
    xee = v.xs ? 1 : int'(v.xe);
    yee = v.ys ? 1 : int'(v.ye);
    r.exp_xn = v.xm << xlz;
    if (v.is_sqrt) begin
      e   = xee - xlz - 1023;
      odd = e & 1;
      ue  = (e - odd) / 2 + 1023;
      r.exp_yn  = v.ym;
      r.exp_odd = (odd != 0);
      r.exp_lat = (xk + 1) + 1;
    end else begin
      ue = (xee - xlz) - (yee - ylz) + 1023;
      r.exp_yn  = v.ym << ylz;
      r.exp_odd = 1'b0;
      r.exp_lat = (xk + 1) + (yk + 1) + 1;
    end
    r.exp_ue = 13'(ue);
    return r;
  endfunction

  function automatic logic [52:0] rand_mant(input bit sub);
    logic [63:0] r = {$urandom, $urandom};
    logic [52:0] m = r[52:0];
    if (!sub) begin
      m[52] = 1'b1;
    end else begin
      m[52] = 1'b0;
      m = m >> $urandom_range(0, 52);
      if ($urandom_range(0, 9) == 0) m = '0;
    end
    return m;
  endfunction

  // One full transaction: accept, wait for Valid, check, optional backpressure, drain
  task automatic do_op(input vec_t v, input int hold, input string tag);
    int cyc = 0;
    bit got = 0;
    check({tag, ".ready_before"}, Ready, 1);
    SqrtE = v.is_sqrt; Xe = v.xe; Ye = v.ye; XSubnorm = v.xs; YSubnorm = v.ys;
    XMant = v.xm; YMant = v.ym; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    while (cyc < 200 && !got) begin
      @(posedge clk); #1;
      cyc++;
      got = Valid;
    end
    check({tag, ".latency"}, got ? 64'(cyc) : 64'hFFFF, 64'(v.exp_lat));
    check({tag, ".xnorm"}, XNorm, v.exp_xn);
    check({tag, ".ynorm"}, YNorm, v.exp_yn);
    check({tag, ".divue"}, DivUe, v.exp_ue);
    check({tag, ".sqrtodd"}, SqrtOdd, v.exp_odd);
    for (int h = 0; h < hold; h++) begin
      // Start while busy must be ignored
      Start = 1'b1; Xe = 11'($urandom); XMant = rand_mant(1'b0); SqrtE = ~v.is_sqrt;
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, Valid, 1);
      check({tag, ".hold_ready"}, Ready, 0);
      check({tag, ".hold_divue"}, DivUe, v.exp_ue);
      check({tag, ".hold_xnorm"}, XNorm, v.exp_xn);
    end
    Start = 1'b0;
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
    check({tag, ".ready_after"}, Ready, 1);
    check({tag, ".valid_after"}, Valid, 0);
    $display("%s: sqrt=%0b xe=%0d ye=%0d xs=%0b ys=%0b lat=%0d divue=%h odd=%0b",
             tag, v.is_sqrt, v.xe, v.ye, v.xs, v.ys, cyc, DivUe, SqrtOdd);
  endtask

  vec_t tbl[7];
  vec_t rv;
  int   vcount;

  initial begin
    resetn = 1'b0; Flush = 1'b0; Start = 1'b0; SqrtE = 1'b0; Xe = '0; Ye = '0;
    XSubnorm = 1'b0; YSubnorm = 1'b0; XMant = '0; YMant = '0; OutReady = 1'b0;

    //         sq  xe    xs xm                  ye    ys ym                 exp_xn  exp_yn              ue      odd lat
    tbl[0] = mk(0, 1023, 0, 53'h18000000000000, 1023, 0, 53'h1C000000000000, 53'h18000000000000, 53'h1C000000000000, 13'h3FF, 0, 3);
    tbl[1] = mk(0, 0,    1, 53'h1,              1023, 0, ONE,                ONE,                ONE,                13'h1FCD, 0, 13);
    tbl[2] = mk(1, 1025, 0, ONE,                0,    0, 53'h123,            ONE,                53'h123,            13'h400, 0, 2);
    tbl[3] = mk(1, 1024, 0, ONE,                0,    0, 53'h77,             ONE,                53'h77,             13'h3FF, 1, 2);
    tbl[4] = mk(0, 0,    1, 53'h0,              1023, 0, ONE,                53'h0,              ONE,                13'h001, 0, 3);
    tbl[5] = mk(0, 1023, 0, ONE,                0,    1, 53'h100,            ONE,                ONE,                13'h829, 0, 12);
    tbl[6] = mk(1, 0,    1, 53'h08000000000000, 0,    0, 53'h5,              ONE,                53'h5,              13'h1FF, 1, 3);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.ready", Ready, 1);
    check("reset.valid", Valid, 0);
    check("reset.xnorm", XNorm, 0);
    check("reset.ynorm", YNorm, 0);
    check("reset.divue", DivUe, 0);
    check("reset.sqrtodd", SqrtOdd, 0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // Table vectors; entry 0 also exercises 5 cycles of backpressure,
    // and the following entry is started right after the drain
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i], (i == 0) ? 5 : 0, $sformatf("vec%0d", i));
    end

    // Flush mid-NORMX with a subnormal X
    SqrtE = 1'b0; Xe = '0; XSubnorm = 1'b1; XMant = 53'h1; Ye = 1023; YSubnorm = 1'b0;
    YMant = ONE; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    check("flush.busy", Ready, 0);
    repeat (3) @(posedge clk);
    #1;
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    check("flush.ready", Ready, 1);
    check("flush.valid", Valid, 0);
    vcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (Valid) vcount++;
    end
    check("flush.no_valid", 64'(vcount), 0);
    $display("flush mid-normx: ready=%0b valid_cycles=%0d", Ready, vcount);

    // Flush together with Start in IDLE: no accept
    Flush = 1'b1; Start = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0; Start = 1'b0;
    check("flush_start.ready", Ready, 1);
    vcount = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (Valid || !Ready) vcount++;
    end
    check("flush_start.idle", 64'(vcount), 0);
    $display("flush+start in idle: ready=%0b busy_cycles=%0d", Ready, vcount);

    // Previous results still held; run one op so DivUe is non-zero before reset test
    do_op(tbl[2], 0, "pre_reset");

    // Async reset asserted while in CALC (normal divide: CALC after edge 2)
    SqrtE = 1'b0; Xe = 1023; Ye = 1023; XSubnorm = 1'b0; YSubnorm = 1'b0;
    XMant = tbl[0].xm; YMant = tbl[0].ym; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("areset.ready", Ready, 1);
    check("areset.valid", Valid, 0);
    check("areset.divue", DivUe, 0);
    check("areset.xnorm", XNorm, 0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    check("areset.resume_idle", Ready, 1);
    check("areset.lost", Valid, 0);
    $display("async reset in calc: ready=%0b valid=%0b divue=%h", Ready, Valid, DivUe);
    do_op(tbl[0], 0, "post_reset");

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      bit xsub = $urandom_range(0, 1) != 0;
      bit ysub = $urandom_range(0, 1) != 0;
      rv.is_sqrt = $urandom_range(0, 2) == 0;
      rv.xs = xsub;
      rv.ys = ysub;
      rv.xe = xsub ? 11'd0 : 11'($urandom_range(1, 2046));
      rv.ye = ysub ? 11'd0 : 11'($urandom_range(1, 2046));
      rv.xm = rand_mant(xsub);
      rv.ym = rand_mant(ysub);
      rv = model(rv);
      do_op(rv, $urandom_range(0, 3), $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
